cs_engine: RTL and testbench
============================

# cs_engine

Parametrised successor to the computational storage core. A command-driven compute-in-memory engine holds a DEPTH×DATA_W register array. It accepts one valid/ready command at a time, reads operands A and B, applies one of NUM_OPS ALU operations with optional saturation, writes the result back to address C, and reports completion with flags. The bidirectional DQ bus is replaced by unidirectional host read/write ports. The block sits under the top-level wrapper, which drives it from the verification interface.

## Interface
- DATA_W, 8, word width (≥2)
- DEPTH, 16, words in array (power of 2, ≥4); AW = $clog2(DEPTH)
- NUM_OPS, 8, legal values 4 or 8; OPW = $clog2(NUM_OPS)
- SATURATE, 0, 1 = ADD/SUB clamp instead of wrap
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en / wr_addr / wr_data  in  1/AW/DATA_W  host write
- rd_en / rd_addr  in  1/AW  host read request
- rd_data  out  DATA_W  host read data; rd_valid  out  1  one-cycle strobe
- host_err  out  1  one-cycle pulse: host access refused
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_op  in  OPW  operation; cmd_addr_a, cmd_addr_b, cmd_addr_c  in  AW
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse in the write-back cycle
- result  out  DATA_W  last computed value; flag_carry, flag_zero  out  1

## Operation
- Array: one synchronous read port, one write port. A read issued in cycle n returns data in n+1. Same-address read and write in one cycle returns old data.
- FSM: IDLE → RD_A → RD_B → EXEC → WB → IDLE, one cycle per state. It leaves IDLE only on cmd_valid & cmd_ready. Command fields are latched at acceptance.
- RD_A issues a read of A. RD_B issues a read of B and captures A. EXEC captures B, computes, and registers result and flags. WB writes result to C and pulses done.
- Ops: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR. When NUM_OPS=8, also 4 XOR, 5 MIN (unsigned), 6 MAX (unsigned), 7 PASS A.
- flag_carry: carry-out for ADD, borrow for SUB, 0 for all other ops. It reports the overflow even when the result is saturated. flag_zero = (result == 0).
- SATURATE=1: an ADD with carry gives all-ones; a SUB with borrow gives 0.
- Host ports are served only in IDLE. wr_en or rd_en in any other state is dropped and host_err pulses the next cycle.
- In IDLE, a host write and a command accepted in the same cycle both proceed. Operand reads then see the new data.
- A == B, or C equal to A or B, is legal. The write-back occurs after both reads.

## Timing
- Command accepted at edge T: busy is high T+1..T+4, done=1 and array write at T+4, cmd_ready high from T+5.
- Throughput is one command per 5 cycles.
- result and flags update at the end of EXEC (visible in WB) and hold until the next EXEC.
- Host read: rd_en in IDLE at T gives rd_data valid and rd_valid=1 at T+1.
- Reset values: state IDLE, cmd_ready 1, busy 0, done 0, rd_valid 0, host_err 0, rd_data 0, result 0, flag_carry 0, flag_zero 0.
- While rst=1, all handshakes and host accesses are ignored.
- Reset mid-operation aborts the command: no write to C and no done pulse. Array contents are not cleared by reset.

## Structure
- Package cs_pkg: op_e enum (ADD..PASS_A), state_e enum (IDLE, RD_A, RD_B, EXEC, WB), and the width helper functions.
- Sub-module cs_alu: combinational. Inputs are a, b, op and the SATURATE parameter. Outputs are y, carry and zero. The FSM, array, and host logic stay in cs_engine.

## Test plan
- Preload [1]=0x05, [2]=0x03; ADD a=1, b=2, c=3 → done at T+4, result 0x08, carry 0, zero 0; host read of addr 3 returns 0x08 one cycle later.
- SUB a=2 (0x03), b=1 (0x05) → SATURATE=0: 0xFE, carry 1; SATURATE=1: 0x00, carry 1, zero 1.
- ADD 0xF0+0x20 → SATURATE=0: 0x10, carry 1; SATURATE=1: 0xFF, carry 1.
- Hold cmd_valid with two commands; wr_en to addr 5 at T+2 → cmd_ready low T+1..T+4, second command accepted at T+5, done at T+9; host_err pulse at T+3; [5] unchanged.
- In-place XOR a=b=c=4, [4]=0x5A → [4]=0x00, zero 1, carry 0; MIN/MAX of 0x80 and 0x7F → 0x7F / 0x80.
- Assert rst during EXEC, with [3] preloaded to 0x11 → [3] stays 0x11, no done pulse, cmd_ready 1 and all outputs at reset values after release.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared types and width helpers for the computational storage engine.
package cs_pkg;

   typedef enum logic [2:0] {
      ADD    = 3'd0,
      SUB    = 3'd1,
      AND    = 3'd2,
      OR     = 3'd3,
      XOR    = 3'd4,
      MIN    = 3'd5,
      MAX    = 3'd6,
      PASS_A = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_e;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int op_w(input int num_ops);
      return (num_ops > 4) ? 3 : 2;
   endfunction

endpackage

// File: rtl/cs_alu.sv
// Combinational ALU: wrap or clamp on ADD/SUB, carry reports overflow either way.
module cs_alu
   import cs_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_OPS  = 8,
   parameter int SATURATE = 0
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  op_e               op,
   output logic [DATA_W-1:0] y,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      y     = '0;
      carry = 1'b0;
      case (op)
         ADD: begin
            carry = sum[DATA_W];
            y     = (SATURATE != 0 && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
         end
         SUB: begin
            carry = diff[DATA_W];
            y     = (SATURATE != 0 && diff[DATA_W]) ? '0 : diff[DATA_W-1:0];
         end
         AND: y = a & b;
         OR:  y = a | b;
         // The upper four ops only exist in the 8-op build.
         XOR:    if (NUM_OPS == 8) y = a ^ b;
         MIN:    if (NUM_OPS == 8) y = (a < b) ? a : b;
         MAX:    if (NUM_OPS == 8) y = (a > b) ? a : b;
         PASS_A: if (NUM_OPS == 8) y = a;
         default: y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/cs_engine.sv
// Command-driven compute-in-memory engine: read A, read B, execute, write back to C.
//   state | meaning
//   IDLE  | host ports served, command accepted
//   RD_A  | array read of operand A issued
//   RD_B  | read of B issued, A captured
//   EXEC  | B arrives, result and flags registered
//   WB    | result written to C, done pulses
module cs_engine
   import cs_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int DEPTH    = 16,
   parameter  int NUM_OPS  = 8,
   parameter  int SATURATE = 0,
   localparam int AW       = addr_w(DEPTH),
   localparam int OPW      = op_w(NUM_OPS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              host_err,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OPW-1:0]    cmd_op,
   input  logic [AW-1:0]     cmd_addr_a,
   input  logic [AW-1:0]     cmd_addr_b,
   input  logic [AW-1:0]     cmd_addr_c,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              flag_carry,
   output logic              flag_zero
);

   state_e            state, state_nx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] opa_q;
   logic [DATA_W-1:0] alu_y;
   logic              alu_carry;
   logic              alu_zero;
   logic [AW-1:0]     a_q, b_q, c_q;
   op_e               op_q;
   logic [2:0]        op_ext;
   logic              idle, accept, host_rd, host_wr;
   logic              rd_fire, mem_we;
   logic [AW-1:0]     raddr, waddr;
   logic [DATA_W-1:0] wdata;

   assign idle      = (state == IDLE);
   assign cmd_ready = idle;
   assign busy      = !idle;
   assign done      = (state == WB);
   assign accept    = cmd_valid & idle;
   assign host_rd   = rd_en & idle;
   assign host_wr   = wr_en & idle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RD_A;
         RD_A:    state_nx = RD_B;
         RD_B:    state_nx = EXEC;
         EXEC:    state_nx = WB;
         WB:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      op_ext          = '0;
      op_ext[OPW-1:0] = cmd_op;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= ADD;
         a_q  <= '0;
         b_q  <= '0;
         c_q  <= '0;
      end else if (accept) begin
         op_q <= op_e'(op_ext);
         a_q  <= cmd_addr_a;
         b_q  <= cmd_addr_b;
         c_q  <= cmd_addr_c;
      end
   end

   // Single read port shared between the host (IDLE only) and operand fetch.
   always_comb begin
      raddr   = rd_addr;
      rd_fire = host_rd;
      case (state)
         RD_A: begin raddr = a_q; rd_fire = 1'b1; end
         RD_B: begin raddr = b_q; rd_fire = 1'b1; end
         default: ;
      endcase
   end

   // Host writes and write-back never coincide: one needs IDLE, the other WB.
   always_comb begin
      mem_we = !rst && (host_wr || done);
      waddr  = done ? c_q    : wr_addr;
      wdata  = done ? result : wr_data;
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          rd_q <= '0;
      else if (rd_fire) rd_q <= mem[raddr];
   end

   assign rd_data = rd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa_q    <= '0;
         rd_valid <= 1'b0;
         host_err <= 1'b0;
      end else begin
         if (state == RD_B) opa_q <= rd_q;
         rd_valid <= host_rd;
         host_err <= (rd_en | wr_en) & !idle;
      end
   end

   cs_alu #(
      .DATA_W   (DATA_W),
      .NUM_OPS  (NUM_OPS),
      .SATURATE (SATURATE)
   ) u_alu (
      .a     (opa_q),
      .b     (rd_q),
      .op    (op_q),
      .y     (alu_y),
      .carry (alu_carry),
      .zero  (alu_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result     <= '0;
         flag_carry <= 1'b0;
         flag_zero  <= 1'b0;
      end else if (state == EXEC) begin
         result     <= alu_y;
         flag_carry <= alu_carry;
         flag_zero  <= alu_zero;
      end
   end

endmodule

// File: tb/tb_cs_engine.sv
// Directed bench: a wrapping and a saturating engine driven in lock-step.
module tb_cs_engine;
   import cs_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, rd_en, cmd_valid;
   logic [3:0] wr_addr, rd_addr, ca, cb, cc;
   logic [7:0] wr_data;
   logic [2:0] cmd_op;

   logic [1:0][7:0] rd_data_v, result_v;
   logic [1:0]      rd_valid_v, host_err_v, cmd_ready_v, busy_v, done_v, carry_v, zero_v;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cs_engine #(.DATA_W(8), .DEPTH(16), .NUM_OPS(8), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]),
      .host_err(host_err_v[0]),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_v[0]), .cmd_op(cmd_op),
      .cmd_addr_a(ca), .cmd_addr_b(cb), .cmd_addr_c(cc),
      .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0]),
      .flag_carry(carry_v[0]), .flag_zero(zero_v[0])
   );

   cs_engine #(.DATA_W(8), .DEPTH(16), .NUM_OPS(8), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]),
      .host_err(host_err_v[1]),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_v[1]), .cmd_op(cmd_op),
      .cmd_addr_a(ca), .cmd_addr_b(cb), .cmd_addr_c(cc),
      .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1]),
      .flag_carry(carry_v[1]), .flag_zero(zero_v[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic host_read(input logic [3:0] a);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
   endtask

   // Accepts one command, then waits (bounded) for done; lat is the cycle
   // index of done counted from the accepting edge, -1 if it never came.
   task automatic issue(input op_e op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, output int lat, output logic [1:0] ds);
      int k;
      cmd_valid = 1'b1; cmd_op = op; ca = a; cb = b; cc = c;
      tick();
      cmd_valid = 1'b0;
      k = 1;
      while (k <= 8 && done_v[0] !== 1'b1) begin
         tick();
         k++;
      end
      lat = (k <= 8) ? k : -1;
      ds  = done_v;
      tick();
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if ({cmd_ready_v[d], busy_v[d], done_v[d], rd_valid_v[d], host_err_v[d], carry_v[d], zero_v[d]} !== 7'b1000000) begin
            n_errors++;
            $display("FAIL reset_ctrl dut%0d: got %b expected 1000000", d,
                     {cmd_ready_v[d], busy_v[d], done_v[d], rd_valid_v[d], host_err_v[d], carry_v[d], zero_v[d]});
         end
         n_checks++;
         if (rd_data_v[d] !== 8'h00 || result_v[d] !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_data dut%0d: rd_data %h result %h expected 00 00", d, rd_data_v[d], result_v[d]);
         end
      end
   endtask

   task automatic test_add();
      int lat; logic [1:0] ds;
      host_write(4'd1, 8'h05);
      host_write(4'd2, 8'h03);
      issue(ADD, 4'd1, 4'd2, 4'd3, lat, ds);
      n_checks++;
      if (lat != 4 || ds !== 2'b11) begin
         n_errors++;
         $display("FAIL add_latency: got %0d done %b expected 4 done 11", lat, ds);
      end
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (result_v[d] !== 8'h08 || carry_v[d] !== 1'b0 || zero_v[d] !== 1'b0) begin
            n_errors++;
            $display("FAIL add_result dut%0d: got %h c%b z%b expected 08 c0 z0", d, result_v[d], carry_v[d], zero_v[d]);
         end
      end
      host_read(4'd3);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (rd_valid_v[d] !== 1'b1 || rd_data_v[d] !== 8'h08) begin
            n_errors++;
            $display("FAIL add_readback dut%0d: got %h valid %b expected 08 valid 1", d, rd_data_v[d], rd_valid_v[d]);
         end
      end
   endtask

   task automatic test_sub_borrow();
      int lat; logic [1:0] ds;
      logic [1:0][7:0] exp_res;
      logic [1:0]      exp_zero;
      exp_res  = {8'h00, 8'hFE};
      exp_zero = 2'b10;
      issue(SUB, 4'd2, 4'd1, 4'd6, lat, ds);
      host_read(4'd6);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (result_v[d] !== exp_res[d] || carry_v[d] !== 1'b1 || zero_v[d] !== exp_zero[d]) begin
            n_errors++;
            $display("FAIL sub_result dut%0d: got %h c%b z%b expected %h c1 z%b", d,
                     result_v[d], carry_v[d], zero_v[d], exp_res[d], exp_zero[d]);
         end
         n_checks++;
         if (rd_data_v[d] !== exp_res[d]) begin
            n_errors++;
            $display("FAIL sub_readback dut%0d: got %h expected %h", d, rd_data_v[d], exp_res[d]);
         end
      end
   endtask

   task automatic test_add_overflow();
      int lat; logic [1:0] ds;
      logic [1:0][7:0] exp_res;
      exp_res = {8'hFF, 8'h10};
      host_write(4'd7, 8'hF0);
      host_write(4'd8, 8'h20);
      issue(ADD, 4'd7, 4'd8, 4'd9, lat, ds);
      host_read(4'd9);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (result_v[d] !== exp_res[d] || carry_v[d] !== 1'b1 || zero_v[d] !== 1'b0) begin
            n_errors++;
            $display("FAIL add_ovf dut%0d: got %h c%b z%b expected %h c1 z0", d,
                     result_v[d], carry_v[d], zero_v[d], exp_res[d]);
         end
         n_checks++;
         if (rd_data_v[d] !== exp_res[d]) begin
            n_errors++;
            $display("FAIL add_ovf_readback dut%0d: got %h expected %h", d, rd_data_v[d], exp_res[d]);
         end
      end
   endtask

   task automatic test_back_to_back();
      host_write(4'd5, 8'h33);
      cmd_valid = 1'b1; cmd_op = ADD; ca = 4'd1; cb = 4'd2; cc = 4'd10;
      tick();
      for (int k = 1; k <= 9; k++) begin
         if (k <= 4) begin
            n_checks++;
            if (cmd_ready_v !== 2'b00 || busy_v !== 2'b11) begin
               n_errors++;
               $display("FAIL b2b_busy k=%0d: ready %b busy %b expected 00 11", k, cmd_ready_v, busy_v);
            end
         end
         if (k == 3 || k == 4) begin
            n_checks++;
            if (host_err_v !== ((k == 3) ? 2'b11 : 2'b00)) begin
               n_errors++;
               $display("FAIL b2b_host_err k=%0d: got %b", k, host_err_v);
            end
         end
         if (k == 4 || k == 9) begin
            n_checks++;
            if (done_v !== 2'b11 || result_v[0] !== ((k == 4) ? 8'h08 : 8'h07)) begin
               n_errors++;
               $display("FAIL b2b_done k=%0d: done %b result %h", k, done_v, result_v[0]);
            end
         end else if (k >= 5) begin
            n_checks++;
            if (done_v !== 2'b00) begin
               n_errors++;
               $display("FAIL b2b_no_done k=%0d: got %b expected 00", k, done_v);
            end
         end
         if (k == 5) begin
            n_checks++;
            if (cmd_ready_v !== 2'b11) begin
               n_errors++;
               $display("FAIL b2b_ready_t5: got %b expected 11", cmd_ready_v);
            end
         end
         if (k == 1) begin cmd_op = OR; ca = 4'd1; cb = 4'd2; cc = 4'd11; end
         if (k == 2) begin wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hEE; end
         if (k == 3) wr_en = 1'b0;
         tick();
         if (k == 5) cmd_valid = 1'b0;
      end
      host_read(4'd5);
      n_checks++;
      if (rd_data_v !== {8'h33, 8'h33}) begin
         n_errors++;
         $display("FAIL b2b_refused_write: got %h expected 3333", rd_data_v);
      end
      host_read(4'd11);
      n_checks++;
      if (rd_data_v !== {8'h07, 8'h07}) begin
         n_errors++;
         $display("FAIL b2b_second_wb: got %h expected 0707", rd_data_v);
      end
   endtask

   task automatic test_xor_inplace();
      int lat; logic [1:0] ds;
      host_write(4'd4, 8'h5A);
      issue(XOR, 4'd4, 4'd4, 4'd4, lat, ds);
      n_checks++;
      if (lat != 4 || result_v !== 16'h0000 || zero_v !== 2'b11 || carry_v !== 2'b00) begin
         n_errors++;
         $display("FAIL xor_inplace: lat %0d result %h z%b c%b expected 4 0000 z11 c00", lat, result_v, zero_v, carry_v);
      end
      host_read(4'd4);
      n_checks++;
      if (rd_data_v !== 16'h0000) begin
         n_errors++;
         $display("FAIL xor_readback: got %h expected 0000", rd_data_v);
      end
   endtask

   task automatic test_minmax();
      int lat; logic [1:0] ds;
      host_write(4'd12, 8'h80);
      host_write(4'd13, 8'h7F);
      issue(MIN, 4'd12, 4'd13, 4'd14, lat, ds);
      n_checks++;
      if (result_v !== {8'h7F, 8'h7F} || carry_v !== 2'b00) begin
         n_errors++;
         $display("FAIL min_result: got %h c%b expected 7f7f c00", result_v, carry_v);
      end
      issue(MAX, 4'd12, 4'd13, 4'd15, lat, ds);
      n_checks++;
      if (result_v !== {8'h80, 8'h80} || carry_v !== 2'b00) begin
         n_errors++;
         $display("FAIL max_result: got %h c%b expected 8080 c00", result_v, carry_v);
      end
      host_read(4'd14);
      n_checks++;
      if (rd_data_v !== {8'h7F, 8'h7F}) begin
         n_errors++;
         $display("FAIL min_readback: got %h expected 7f7f", rd_data_v);
      end
   endtask

   task automatic test_reset_abort();
      logic [1:0] seen;
      host_write(4'd3, 8'h11);
      cmd_valid = 1'b1; cmd_op = ADD; ca = 4'd1; cb = 4'd2; cc = 4'd3;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      n_checks++;
      if (busy_v !== 2'b11) begin
         n_errors++;
         $display("FAIL abort_in_exec: busy %b expected 11", busy_v);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (busy_v !== 2'b00 || done_v !== 2'b00) begin
         n_errors++;
         $display("FAIL abort_async: busy %b done %b expected 00 00", busy_v, done_v);
      end
      tick();
      tick();
      rst = 1'b0;
      test_reset();
      seen = 2'b00;
      for (int i = 0; i < 6; i++) begin
         seen = seen | done_v;
         tick();
      end
      n_checks++;
      if (seen !== 2'b00) begin
         n_errors++;
         $display("FAIL abort_done: got %b expected 00", seen);
      end
      host_read(4'd3);
      n_checks++;
      if (rd_data_v !== {8'h11, 8'h11}) begin
         n_errors++;
         $display("FAIL abort_no_wb: got %h expected 1111", rd_data_v);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      cmd_valid = 1'b0; cmd_op = '0; ca = '0; cb = '0; cc = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_add();
      test_sub_borrow();
      test_add_overflow();
      test_back_to_back();
      test_xor_inplace();
      test_minmax();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
